// File: rtl/sr_latch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_latch_pkg
// Purpose  : Shared definitions for the sr_latch block: the encodings of the
//            CONFLICT_MODE parameter and the per-bit next-state function.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sr_latch_pkg;

    // Resolution applied to a bit whose set and reset requests are both high.
    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        SET_WINS = 2'd1,
        RST_WINS = 2'd2,
        TOGGLE   = 2'd3
    } conflict_mode_e;

    // Next value of one storage bit given its requests and present value.
    function automatic logic sr_next(input conflict_mode_e mode,
                                     input logic           s,
                                     input logic           r,
                                     input logic           q);
        logic v;
        v = q;
        case ({s, r})
            2'b10:   v = 1'b1;
            2'b01:   v = 1'b0;
            2'b00:   v = q;
            default: begin
                case (mode)
                    SET_WINS: v = 1'b1;
                    RST_WINS: v = 1'b0;
                    TOGGLE:   v = ~q;
                    default:  v = q;
                endcase
            end
        endcase
        return v;
    endfunction

endpackage : sr_latch_pkg
`default_nettype wire

// File: rtl/sr_cell.sv
`default_nettype none
// ============================================================================
// Module   : sr_cell
// Purpose  : One clocked SR storage bit with configurable S=R=1 resolution.
// Ports    : clk      - rising-edge clock
//            rst_n    - asynchronous active-low reset (q <= RESET_VAL)
//            s, r     - set / reset requests, sampled on clk
//            q        - stored bit
//            conflict - combinational flag, high while s and r are both high
// Revision : 1.0 - initial release
// ============================================================================
module sr_cell
    import sr_latch_pkg::*;
#(
    parameter int   CONFLICT_MODE = 0,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic r,
    output logic q,
    output logic conflict
);

    localparam conflict_mode_e c_MODE = conflict_mode_e'(CONFLICT_MODE[1:0]);

    logic r_q;
    logic w_q_next;

    always_comb begin
        w_q_next = sr_next(c_MODE, s, r, r_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign q        = r_q;
    // Left unregistered so the parent can register it once into err.
    assign conflict = s & r;

endmodule : sr_cell
`default_nettype wire

// File: rtl/sr_latch.sv
`default_nettype none
// ============================================================================
// Module   : sr_latch
// Purpose  : WIDTH independent clocked SR storage bits with a registered
//            conflict indicator.
// Ports    : clk     - rising-edge clock for all state
//            rst_n   - asynchronous active-low reset
//            S, R    - per-bit set / reset requests [WIDTH]
//            Q, Qn   - stored state and its complement [WIDTH]
//            err     - high the cycle after any bit sampled S=R=1
//            err_clr - clears a sticky err (sticky build only)
// Build    : define SR_LATCH_ERR_STICKY_EN to make err sticky until err_clr
//            is sampled high; otherwise err is a one-cycle pulse.
// Revision : 1.0 - initial release
// ============================================================================
module sr_latch
    import sr_latch_pkg::*;
#(
    parameter int               WIDTH         = 1,
    parameter int               CONFLICT_MODE = int'(HOLD),
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             err,
    input  logic             err_clr
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_conflict;
    logic             w_err_next;
    logic             r_err;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .CONFLICT_MODE (CONFLICT_MODE),
            .RESET_VAL     (RESET_VAL[i])
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .s        (S[i]),
            .r        (R[i]),
            .q        (w_q[i]),
            .conflict (w_conflict[i])
        );
    end

`ifdef SR_LATCH_ERR_STICKY_EN
    // A fresh conflict takes priority over a clear in the same cycle.
    always_comb begin
        w_err_next = (|w_conflict) | (r_err & ~err_clr);
    end
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;

    always_comb begin
        w_err_next = |w_conflict;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_next;
        end
    end

    // Qn derived from Q so the pair can never agree, including in reset.
    assign Q   = w_q;
    assign Qn  = ~w_q;
    assign err = r_err;

endmodule : sr_latch
`default_nettype wire

// File: tb/tb_sr_latch.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_latch
// Purpose  : Directed self-checking bench for sr_latch. Four WIDTH=1
//            instances (one per conflict mode) share stimulus; two WIDTH=4
//            instances cover per-bit independence and a non-zero RESET_VAL.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_latch;

    logic       clk;
    logic       rst_n;
    logic       err_clr;
    logic       s1, r1;
    logic [3:0] s4, r4;

    logic [3:0] q1, qn1, e1;
    logic [3:0] q4, qn4, q4v, qn4v;
    logic       e4, e4v;

    int n_cmp;
    int n_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar m = 0; m < 4; m++) begin : g_mode
        sr_latch #(
            .WIDTH         (1),
            .CONFLICT_MODE (m),
            .RESET_VAL     (1'b0)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .S       (s1),
            .R       (r1),
            .Q       (q1[m]),
            .Qn      (qn1[m]),
            .err     (e1[m]),
            .err_clr (err_clr)
        );
    end

    sr_latch #(
        .WIDTH         (4),
        .CONFLICT_MODE (0),
        .RESET_VAL     (4'b0000)
    ) u_w4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .S       (s4),
        .R       (r4),
        .Q       (q4),
        .Qn      (qn4),
        .err     (e4),
        .err_clr (err_clr)
    );

    sr_latch #(
        .WIDTH         (4),
        .CONFLICT_MODE (3),
        .RESET_VAL     (4'b1010)
    ) u_w4v (
        .clk     (clk),
        .rst_n   (rst_n),
        .S       (s4),
        .R       (r4),
        .Q       (q4v),
        .Qn      (qn4v),
        .err     (e4v),
        .err_clr (err_clr)
    );

`ifdef SR_LATCH_ERR_STICKY_EN
    localparam logic c_STICKY = 1'b1;
`else
    localparam logic c_STICKY = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b1;
        err_clr = 1'b0;
        s1 = 1'b0; r1 = 1'b0;
        s4 = 4'b0; r4 = 4'b0;

        // Reset before any clock edge takes effect immediately.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_q",    q1,   4'b0000);
        chk("rst_qn",   qn1,  4'b1111);
        chk("rst_err",  e1,   4'b0000);
        chk("rst_qv",   q4v,  4'b1010);
        chk("rst_qnv",  qn4v, 4'b0101);

        // Set request held during reset is ignored.
        s1 = 1'b1;
        tick();
        chk("rst_ignore_s", q1, 4'b0000);
        chk("rst_ignore_qn", qn1, 4'b1111);

        rst_n = 1'b0;
        rst_n = 1'b1;
        s4 = 4'b0101; r4 = 4'b0011;
        tick();
        chk("set_q",    q1,  4'b1111);
        chk("set_qn",   qn1, 4'b0000);
        chk("set_err",  e1,  4'b0000);
        // Bit0 conflict (hold / toggle), bit1 reset, bit2 set, bit3 hold.
        chk("w4_q",     q4,   4'b0100);
        chk("w4_qn",    qn4,  4'b1011);
        chk("w4_err",   e4,   1'b1);
        chk("w4v_q",    q4v,  4'b1101);
        chk("w4v_err",  e4v,  1'b1);

        s1 = 1'b0; r1 = 1'b1;
        s4 = 4'b0; r4 = 4'b0;
        tick();
        chk("clr_q",    q1,  4'b0000);
        chk("clr_qn",   qn1, 4'b1111);
        chk("w4_err_after", e4, c_STICKY);

        r1 = 1'b0;
        tick();
        chk("hold_q",   q1,  4'b0000);

        s1 = 1'b1;
        tick();
        chk("reset_q",  q1,  4'b1111);

        // Conflict from Q=1: modes 0..3 give 1,1,0,0 (bit index = mode).
        r1 = 1'b1;
        tick();
        chk("cfl_q",    q1,  4'b0011);
        chk("cfl_qn",   qn1, 4'b1100);
        chk("cfl_err",  e1,  4'b1111);

        s1 = 1'b0; r1 = 1'b0;
        tick();
        chk("err_c1",   e1, {4{c_STICKY}});
        chk("cfl_hold", q1, 4'b0011);
        tick();
        chk("err_c2",   e1, {4{c_STICKY}});
        tick();
        chk("err_c3",   e1, {4{c_STICKY}});

        err_clr = 1'b1;
        tick();
        chk("err_clr",  e1, 4'b0000);

        // A new conflict beats a simultaneous clear.
        s1 = 1'b1; r1 = 1'b1;
        tick();
        chk("err_clr_cfl", e1, 4'b1111);
        err_clr = 1'b0;
        s1 = 1'b0; r1 = 1'b0;
        tick();
        chk("err_after_cfl", e1, {4{c_STICKY}});
        err_clr = 1'b1;
        tick();
        chk("err_clr2", e1, 4'b0000);
        err_clr = 1'b0;

        // Mid-cycle reset overrides a pending set, then first edge sets.
        s1 = 1'b1;
        tick();
        chk("pre_rst_q", q1, 4'b1111);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_q",  q1,  4'b0000);
        chk("mid_rst_qn", qn1, 4'b1111);
        chk("mid_rst_qv", q4v, 4'b1010);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_q", q1,  4'b1111);
        chk("post_rst_qn", qn1, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sr_latch
`default_nettype wire
